mc_main_ctrl: RTL and testbench

- Main control state machine for the multi-cycle MIPS datapath.
- Decodes the 6-bit opcode held in the instruction register and sequences the datapath through fetch, decode, execute, memory and write-back cycles.
- Drives every datapath enable and mux select, including the 2-bit ALUop consumed by the ALU control decoder:
  - 00 = add
  - 01 = subtract
  - 10 = decode from Func
- Handles a variable-latency memory through a ready handshake.

---
 rtl/mc_main_ctrl_if.sv | 42 ++++
 rtl/mc_main_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_mc_main_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_main_ctrl_if.sv
// Control bus between the main controller and the multi-cycle datapath.
// master: the controller. It samples Op/mem_ready and drives every
//         enable and select.
// slave:  the datapath and memory side. It drives Op/mem_ready and
//         consumes the controls.
// Signals: Op, mem_ready, PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
//          IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB[1:0],
//          ALUop[1:0], PCSource[1:0], instr_retire, illegal_op, state_o[3:0]
interface mc_main_ctrl_if;
    logic [5:0] Op;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUop;
    logic [1:0] PCSource;
    logic       instr_retire;
    logic       illegal_op;
    logic [3:0] state_o;

    modport master (
        input  Op, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop,
               PCSource, instr_retire, illegal_op, state_o
    );

    modport slave (
        output Op, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop,
               PCSource, instr_retire, illegal_op, state_o
    );
endinterface

// File: rtl/mc_main_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath.
// It decodes the IR opcode and steps the datapath through the fetch,
// decode, execute, memory and write-back cycles. Memory accesses wait
// on mem_ready.
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - mc_main_ctrl_if.master: Op/mem_ready in, all datapath controls,
//            instr_retire, sticky illegal_op and debug state_o out
// Parameter HALT_ON_ILLEGAL: 1 = an unsupported opcode halts until reset,
//                            0 = it retires as a NOP.
// The controls are decoded combinationally from the state register. FETCH
// and MEMWR also use mem_ready. This way a reset assertion drops every
// enable at once, without waiting for a clock edge.
module mc_main_ctrl #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    mc_main_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC    = 4'd7,
        S_RWB     = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10,
        S_ADDIEX  = 4'd11,
        S_ADDIWB  = 4'd12,
        S_ILLEGAL = 4'd13,
        S_HALT    = 4'd14,
        S_UNUSED  = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t     state_r;
    state_t     next_state_s;
    logic       illegal_r;

    logic       pc_write_s;
    logic       pc_write_cond_s;
    logic       iord_s;
    logic       mem_read_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       mem_to_reg_s;
    logic       reg_dst_s;
    logic       reg_write_s;
    logic       alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] alu_op_s;
    logic [1:0] pc_source_s;
    logic       retire_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Sticky illegal-opcode flag. It is set on entry to ILLEGAL, so it is
    // already visible in that state. Only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_r <= 1'b0;
        end else if (next_state_s == S_ILLEGAL) begin
            illegal_r <= 1'b1;
        end else begin
            illegal_r <= illegal_r;
        end
    end

    // Next-state and control decode.
    always_comb begin
        next_state_s    = state_r;
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        iord_s          = 1'b0;
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        ir_write_s      = 1'b0;
        mem_to_reg_s    = 1'b0;
        reg_dst_s       = 1'b0;
        reg_write_s     = 1'b0;
        alu_src_a_s     = 1'b0;
        alu_src_b_s     = 2'b00;
        alu_op_s        = 2'b00;
        pc_source_s     = 2'b00;
        retire_s        = 1'b0;

        case (state_r)
            S_IDLE: begin
                next_state_s = S_FETCH;
            end
            S_FETCH: begin
                // PC+4 goes through the ALU. The IR and PC load only when
                // the memory delivers the instruction.
                mem_read_s  = 1'b1;
                alu_src_b_s = 2'b01;
                if (bus.mem_ready) begin
                    ir_write_s   = 1'b1;
                    pc_write_s   = 1'b1;
                    next_state_s = S_DECODE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                // Compute the branch target early so BRANCH can use ALUOut.
                alu_src_b_s = 2'b11;
                case (bus.Op)
                    OP_LW:    next_state_s = S_MEMADR;
                    OP_SW:    next_state_s = S_MEMADR;
                    OP_RTYPE: next_state_s = S_EXEC;
                    OP_BEQ:   next_state_s = S_BRANCH;
                    OP_J:     next_state_s = S_JUMP;
                    OP_ADDI:  next_state_s = S_ADDIEX;
                    default:  next_state_s = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
                if (bus.Op == OP_SW) begin
                    next_state_s = S_MEMWR;
                end else begin
                    next_state_s = S_MEMRD;
                end
            end
            S_MEMRD: begin
                mem_read_s = 1'b1;
                iord_s     = 1'b1;
                if (bus.mem_ready) begin
                    next_state_s = S_MEMWB;
                end else begin
                    next_state_s = S_MEMRD;
                end
            end
            S_MEMWB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
                retire_s     = 1'b1;
                next_state_s = S_FETCH;
            end
            S_MEMWR: begin
                mem_write_s = 1'b1;
                iord_s      = 1'b1;
                if (bus.mem_ready) begin
                    retire_s     = 1'b1;
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_MEMWR;
                end
            end
            S_EXEC: begin
                alu_src_a_s  = 1'b1;
                alu_op_s     = 2'b10;
                next_state_s = S_RWB;
            end
            S_RWB: begin
                reg_write_s  = 1'b1;
                reg_dst_s    = 1'b1;
                retire_s     = 1'b1;
                next_state_s = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_s     = 1'b1;
                alu_op_s        = 2'b01;
                pc_write_cond_s = 1'b1;
                pc_source_s     = 2'b01;
                retire_s        = 1'b1;
                next_state_s    = S_FETCH;
            end
            S_JUMP: begin
                pc_write_s   = 1'b1;
                pc_source_s  = 2'b10;
                retire_s     = 1'b1;
                next_state_s = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a_s  = 1'b1;
                alu_src_b_s  = 2'b10;
                next_state_s = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_s  = 1'b1;
                retire_s     = 1'b1;
                next_state_s = S_FETCH;
            end
            S_ILLEGAL: begin
                if (HALT_ON_ILLEGAL) begin
                    next_state_s = S_HALT;
                end else begin
                    retire_s     = 1'b1;
                    next_state_s = S_FETCH;
                end
            end
            S_HALT: begin
                next_state_s = S_HALT;
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase
    end

    assign bus.PCWrite      = pc_write_s;
    assign bus.PCWriteCond  = pc_write_cond_s;
    assign bus.IorD         = iord_s;
    assign bus.MemRead      = mem_read_s;
    assign bus.MemWrite     = mem_write_s;
    assign bus.IRWrite      = ir_write_s;
    assign bus.MemtoReg     = mem_to_reg_s;
    assign bus.RegDst       = reg_dst_s;
    assign bus.RegWrite     = reg_write_s;
    assign bus.ALUSrcA      = alu_src_a_s;
    assign bus.ALUSrcB      = alu_src_b_s;
    assign bus.ALUop        = alu_op_s;
    assign bus.PCSource     = pc_source_s;
    assign bus.instr_retire = retire_s;
    assign bus.illegal_op   = illegal_r;
    assign bus.state_o      = state_r;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Testbench for mc_main_ctrl. Two instances run side by side on the same
// Op/mem_ready: one halts on an illegal opcode and the other retires it as
// a NOP. For every instruction the bench builds the expected per-cycle
// phase list from the opcode and the planned memory wait counts. Each
// cycle, the full control vector of both instances is compared with that
// list.
module tb_mc_main_ctrl;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op_v = 6'd0;
    logic       rdy_v = 1'b0;

    int checks = 0;
    int errors = 0;

    // Model state: sticky illegal flags and whether the halting copy stopped.
    bit ill_n = 1'b0;
    bit ill_h = 1'b0;
    bit halted_h = 1'b0;
    int halt_cycles = 0;

    always #5 clk = ~clk;

    mc_main_ctrl_if bus_h ();
    mc_main_ctrl_if bus_n ();

    assign bus_h.Op = op_v;
    assign bus_h.mem_ready = rdy_v;
    assign bus_n.Op = op_v;
    assign bus_n.mem_ready = rdy_v;

    mc_main_ctrl #(.HALT_ON_ILLEGAL(1'b1)) dut_h (.clk(clk), .rst_n(rst_n), .bus(bus_h));
    mc_main_ctrl #(.HALT_ON_ILLEGAL(1'b0)) dut_n (.clk(clk), .rst_n(rst_n), .bus(bus_n));

    // Order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst
    //        RegWrite ALUSrcA ALUSrcB ALUop PCSource retire illegal state
    logic [21:0] act_h;
    logic [21:0] act_n;
    assign act_h = {bus_h.PCWrite, bus_h.PCWriteCond, bus_h.IorD, bus_h.MemRead,
                    bus_h.MemWrite, bus_h.IRWrite, bus_h.MemtoReg, bus_h.RegDst,
                    bus_h.RegWrite, bus_h.ALUSrcA, bus_h.ALUSrcB, bus_h.ALUop,
                    bus_h.PCSource, bus_h.instr_retire, bus_h.illegal_op, bus_h.state_o};
    assign act_n = {bus_n.PCWrite, bus_n.PCWriteCond, bus_n.IorD, bus_n.MemRead,
                    bus_n.MemWrite, bus_n.IRWrite, bus_n.MemtoReg, bus_n.RegDst,
                    bus_n.RegWrite, bus_n.ALUSrcA, bus_n.ALUSrcB, bus_n.ALUop,
                    bus_n.PCSource, bus_n.instr_retire, bus_n.illegal_op, bus_n.state_o};

    // Expected control vector for one phase, taken from the state table.
    function automatic logic [21:0] exp_vec(input int code, input bit rdy,
                                            input bit ill, input bit halt);
        logic pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ret;
        logic [1:0] srcb, aop, pcs;
        pcw = 1'b0; pcc = 1'b0; iord = 1'b0; mrd = 1'b0; mwr = 1'b0;
        irw = 1'b0; m2r = 1'b0; rdst = 1'b0; rw = 1'b0; srca = 1'b0;
        ret = 1'b0; srcb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (code)
            1:  begin mrd = 1'b1; srcb = 2'b01; irw = rdy; pcw = rdy; end
            2:  srcb = 2'b11;
            3:  begin srca = 1'b1; srcb = 2'b10; end
            4:  begin mrd = 1'b1; iord = 1'b1; end
            5:  begin rw = 1'b1; m2r = 1'b1; ret = 1'b1; end
            6:  begin mwr = 1'b1; iord = 1'b1; ret = rdy; end
            7:  begin srca = 1'b1; aop = 2'b10; end
            8:  begin rw = 1'b1; rdst = 1'b1; ret = 1'b1; end
            9:  begin srca = 1'b1; aop = 2'b01; pcc = 1'b1; pcs = 2'b01; ret = 1'b1; end
            10: begin pcw = 1'b1; pcs = 2'b10; ret = 1'b1; end
            11: begin srca = 1'b1; srcb = 2'b10; end
            12: begin rw = 1'b1; ret = 1'b1; end
            13: ret = !halt;
            default: ;
        endcase
        return {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop,
                pcs, ret, ill, code[3:0]};
    endfunction

    // Instruction length from the cycle-count rules: base latency plus
    // one cycle per memory wait state.
    function automatic int exp_cycles(input logic [5:0] op, input int fw, input int mw);
        case (op)
            OP_LW:   return 5 + fw + mw;
            OP_SW:   return 4 + fw + mw;
            OP_R:    return 4 + fw;
            OP_ADDI: return 4 + fw;
            default: return 3 + fw;
        endcase
    endfunction

    task automatic check_vec(input string name, input logic [21:0] act, input logic [21:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs one instruction with fw fetch waits and mw data-memory waits.
    // Every cycle is checked, and the cycle on which the NOP-mode copy
    // retired is returned (-1 if it never retired).
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                             output int cyc);
        int codes[$];
        bit rdys[$];
        int hcode;
        repeat (fw) begin codes.push_back(1); rdys.push_back(1'b0); end
        codes.push_back(1); rdys.push_back(1'b1);
        // Outside the wait states mem_ready is random and must be ignored.
        codes.push_back(2); rdys.push_back(1'($urandom_range(0, 1)));
        case (op)
            OP_LW: begin
                codes.push_back(3); rdys.push_back(1'($urandom_range(0, 1)));
                repeat (mw) begin codes.push_back(4); rdys.push_back(1'b0); end
                codes.push_back(4); rdys.push_back(1'b1);
                codes.push_back(5); rdys.push_back(1'($urandom_range(0, 1)));
            end
            OP_SW: begin
                codes.push_back(3); rdys.push_back(1'($urandom_range(0, 1)));
                repeat (mw) begin codes.push_back(6); rdys.push_back(1'b0); end
                codes.push_back(6); rdys.push_back(1'b1);
            end
            OP_R: begin
                codes.push_back(7); rdys.push_back(1'($urandom_range(0, 1)));
                codes.push_back(8); rdys.push_back(1'($urandom_range(0, 1)));
            end
            OP_BEQ:  begin codes.push_back(9);  rdys.push_back(1'($urandom_range(0, 1))); end
            OP_J:    begin codes.push_back(10); rdys.push_back(1'($urandom_range(0, 1))); end
            OP_ADDI: begin
                codes.push_back(11); rdys.push_back(1'($urandom_range(0, 1)));
                codes.push_back(12); rdys.push_back(1'($urandom_range(0, 1)));
            end
            default: begin codes.push_back(13); rdys.push_back(1'($urandom_range(0, 1))); end
        endcase
        cyc = -1;
        for (int i = 0; i < codes.size(); i++) begin
            @(negedge clk);
            op_v = op;
            rdy_v = rdys[i];
            #1;
            if (codes[i] == 13) ill_n = 1'b1;
            hcode = halted_h ? 14 : codes[i];
            if (hcode == 13) ill_h = 1'b1;
            check_vec("nop_ctrl", act_n, exp_vec(codes[i], rdys[i], ill_n, 1'b0));
            check_vec("halt_ctrl", act_h, exp_vec(hcode, rdys[i], ill_h, 1'b1));
            if (bus_h.state_o == 4'd14) halt_cycles++;
            if (hcode == 13) halted_h = 1'b1;
            if (bus_n.instr_retire && cyc < 0) cyc = i + 1;
        end
    endtask

    typedef struct {
        logic [5:0] op;
        int         fw;
        int         mw;
        int         cycles;
        string      name;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int cyc;
        logic [5:0] rop;
        int rfw;
        int rmw;
        logic [5:0] ops[6];

        tbl[0]  = '{OP_LW,   0, 0, 5, "lw_zero_wait"};
        tbl[1]  = '{OP_R,    3, 0, 7, "rtype_fetch_stall"};
        tbl[2]  = '{OP_BAD,  0, 0, 3, "illegal_op"};
        tbl[3]  = '{OP_LW,   1, 2, 8, "lw_waits"};
        tbl[4]  = '{OP_SW,   0, 2, 6, "sw_two_wait"};
        tbl[5]  = '{OP_BEQ,  0, 0, 3, "beq"};
        tbl[6]  = '{OP_J,    0, 0, 3, "j"};
        tbl[7]  = '{OP_ADDI, 0, 0, 4, "addi"};
        tbl[8]  = '{OP_ADDI, 2, 0, 6, "addi_fetch_stall"};
        tbl[9]  = '{OP_R,    0, 0, 4, "rtype"};
        tbl[10] = '{OP_SW,   0, 0, 4, "sw_zero_wait"};
        ops[0] = OP_R; ops[1] = OP_LW; ops[2] = OP_SW;
        ops[3] = OP_BEQ; ops[4] = OP_J; ops[5] = OP_ADDI;

        // Reset held, then released: IDLE with all outputs low.
        repeat (3) @(negedge clk);
        #1;
        check_vec("reset_h", act_h, 22'd0);
        check_vec("reset_n", act_n, 22'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_vec("idle_h", act_h, 22'd0);
        check_vec("idle_n", act_n, 22'd0);

        // Directed vectors.
        for (int i = 0; i < 11; i++) begin
            run_instr(tbl[i].op, tbl[i].fw, tbl[i].mw, cyc);
            check_int(tbl[i].name, cyc, tbl[i].cycles);
        end
        check_int("halt_held_20", (halt_cycles >= 20) ? 1 : 0, 1);
        check_int("halt_state", int'(bus_h.state_o), 14);

        // Reset asserted in the middle of a store. The write must drop at once.
        @(negedge clk); op_v = OP_SW; rdy_v = 1'b1;
        @(negedge clk); rdy_v = 1'b0;
        @(negedge clk);
        @(negedge clk); rdy_v = 1'b0;
        #1;
        check_int("memwr_before_reset", int'({bus_n.MemWrite, bus_n.state_o}), 16 + 6);
        #2;
        rst_n = 1'b0;
        #1;
        check_vec("async_reset_n", act_n, 22'd0);
        check_vec("async_reset_h", act_h, 22'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ill_n = 1'b0; ill_h = 1'b0; halted_h = 1'b0;
        #1;
        check_vec("post_reset_idle", act_n, 22'd0);
        run_instr(OP_SW, 1, 1, cyc);
        check_int("sw_after_reset", cyc, 6);

        // Randomized instructions against the phase-list model.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) rop = OP_BAD;
            else rop = ops[$urandom_range(0, 5)];
            rfw = $urandom_range(0, 3);
            rmw = $urandom_range(0, 3);
            run_instr(rop, rfw, rmw, cyc);
            check_int("rand_cycles", cyc, exp_cycles(rop, rfw, rmw));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
